shuffle_solve_ctrl: RTL

Parametrised game-flow controller for the puzzle board. It detects scramble-button presses and emits a burst of pseudo-random shuffle moves from an internal LFSR, paced for the board logic. It then counts player moves until the board checker reports solved, and drives the buzzer for a fixed win period. It sits between the debounced button inputs, the board/move-apply logic and the buzzer driver.

---
 rtl/shuffle_solve_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/shuffle_solve_ctrl.sv
// shuffle_solve_ctrl: scramble detection, LFSR shuffle burst, move counting and win buzzer
module shuffle_solve_ctrl #(
   parameter int SEED          = 31,
   parameter int LFSR_WIDTH    = 16,
   parameter int MOVE_WIDTH    = 4,
   parameter int SHUFFLE_MOVES = 31,
   parameter int MOVE_GAP      = 4,
   parameter int BUZZ_CYCLES   = 25_000_000,
   parameter int COUNT_WIDTH   = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   scramble_btn,
   input  logic                   player_move,
   input  logic                   solved,
   output logic [MOVE_WIDTH-1:0]  shuffle_move,
   output logic                   shuffle_valid,
   output logic                   shuffling,
   output logic                   playing,
   output logic                   buzz,
   output logic [COUNT_WIDTH-1:0] move_count
);
   localparam int GAP_W  = $clog2(MOVE_GAP + 1);
   localparam int IDX_W  = $clog2(SHUFFLE_MOVES + 1);
   localparam int BUZZ_W = $clog2(BUZZ_CYCLES + 1);
   localparam logic [LFSR_WIDTH-1:0] SEED_VAL = (SEED == 0) ? LFSR_WIDTH'(1) : LFSR_WIDTH'(SEED);

   // one-hot so each status output is a flop bit rather than a decode
   typedef enum logic [3:0] {IDLE = 4'b0001, SHUFFLE = 4'b0010, PLAY = 4'b0100, WIN = 4'b1000} stateType;

   stateType              state, nextState;
   logic [GAP_W-1:0]      gapCnt;
   logic [IDX_W-1:0]      moveIdx;
   logic [BUZZ_W-1:0]     buzzCnt;
   logic [LFSR_WIDTH-1:0] lfsr;
   logic                  btnPrev, btnEdge, gapLast, idxLast, buzzLast, pulseNext, validReg;

   assign btnEdge  = scramble_btn & ~btnPrev;
   assign gapLast  = gapCnt == GAP_W'(MOVE_GAP - 1);
   assign idxLast  = moveIdx == IDX_W'(SHUFFLE_MOVES - 1);
   assign buzzLast = buzzCnt == BUZZ_W'(BUZZ_CYCLES - 1);
   // a pulse is due whenever the next cycle is a SHUFFLE cycle whose gap counter restarts at 0
   assign pulseNext = (nextState == SHUFFLE) && !(state[1] && !gapLast);

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= nextState;
   end

   // next-state logic; scramble edges outrank solved and the buzz timeout
   always_comb begin
      nextState = IDLE;
      case (state)
         IDLE:    nextState = btnEdge ? SHUFFLE : IDLE;
         SHUFFLE: nextState = (gapLast && idxLast) ? PLAY : SHUFFLE;
         PLAY:    nextState = btnEdge ? SHUFFLE : solved ? WIN : PLAY;
         WIN:     nextState = btnEdge ? SHUFFLE : buzzLast ? IDLE : WIN;
         default: nextState = IDLE;
      endcase
   end

   // status outputs straight from the one-hot state and the registered pulse
   always_comb begin
      shuffling     = state[1];
      playing       = state[2];
      buzz          = state[3];
      shuffle_valid = validReg;
   end

   // free-running LFSR, pacing counters (zero outside their state), move code and move counter
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr         <= SEED_VAL;
         btnPrev      <= 1'b1;
         gapCnt       <= '0;
         moveIdx      <= '0;
         buzzCnt      <= '0;
         validReg     <= 1'b0;
         shuffle_move <= '0;
         move_count   <= '0;
      end else begin
         lfsr         <= {lfsr[LFSR_WIDTH-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         btnPrev      <= scramble_btn;
         gapCnt       <= (state[1] && !gapLast) ? gapCnt + GAP_W'(1) : '0;
         moveIdx      <= state[1] ? moveIdx + IDX_W'(gapLast) : '0;
         buzzCnt      <= (state[3] && nextState == WIN) ? buzzCnt + BUZZ_W'(1) : '0;
         validReg     <= pulseNext;
         shuffle_move <= pulseNext ? lfsr[MOVE_WIDTH-1:0] : shuffle_move;
         move_count   <= (btnEdge && !state[1]) ? '0 :
                         (state[2] && player_move && !(&move_count)) ? move_count + COUNT_WIDTH'(1) : move_count;
      end
   end
endmodule
